// File: rtl/retire_trace_fifo_if.sv
// -----------------------------------------------------------------------------
// retire_trace_fifo_if
// Bundles the retire-side capture bus coming from writeback and the
// logger-side valid/ready output bus of the retire trace FIFO.
//   ret_*   : one retired instruction per cycle (ret_valid qualifies)
//   out_*   : head entry presented to the logger, out_valid/out_ready handshake
// Modports:
//   master : the producer/consumer environment (core + logger)
//   slave  : the trace FIFO itself
// -----------------------------------------------------------------------------
interface retire_trace_fifo_if #(
    parameter int CYC_W = 64
) ();
    logic              ret_valid;
    logic [31:0]       ret_pc;
    logic [31:0]       ret_inst;
    logic              ret_rd_we;
    logic [4:0]        ret_rd;
    logic [31:0]       ret_rd_wdata;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic              out_rd_we;
    logic [4:0]        out_rd;
    logic [31:0]       out_wdata;
    logic [CYC_W-1:0]  out_cycle;
    logic [31:0]       out_seq;
    logic              out_gap;

    modport master (
        output ret_valid, ret_pc, ret_inst, ret_rd_we, ret_rd, ret_rd_wdata,
        output out_ready,
        input  out_valid, out_pc, out_inst, out_rd_we, out_rd, out_wdata,
        input  out_cycle, out_seq, out_gap
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_rd_we, ret_rd, ret_rd_wdata,
        input  out_ready,
        output out_valid, out_pc, out_inst, out_rd_we, out_rd, out_wdata,
        output out_cycle, out_seq, out_gap
    );
endinterface

// File: rtl/retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// retire_trace_fifo
// Captures every retired instruction (PC, instruction word, register
// writeback), tags it with a free-running cycle stamp and a retire sequence
// number, and buffers it in a first-word-fall-through FIFO towards the trace
// logger. Logger back-pressure never stalls the core: when the FIFO is full a
// retire is dropped, counted in drop_cnt, and the next accepted entry carries
// out_gap=1.
// Ports:
//   clk, rst  : core clock, asynchronous active-high reset
//   trace_en  : capture enable; disabled retires are neither stored nor dropped
//   bus       : retire capture bus and logger output bus (slave modport)
//   drop_cnt  : saturating count of dropped retires
//   level     : current FIFO occupancy
// -----------------------------------------------------------------------------
module retire_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    retire_trace_fifo_if.slave       bus,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             rd_we;
        logic [4:0]       rd;
        logic [31:0]      wdata;
        logic [CYC_W-1:0] cycle;
        logic [31:0]      seq;
        logic             gap;
    } entry_t;

    entry_t           mem_r [DEPTH];
    logic [CYC_W-1:0] cycle_r;
    logic [31:0]      seq_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [15:0]      drop_cnt_r;
    logic             gap_pending_r;

    logic             event_s;
    logic             not_empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [CW-1:0]    count_next_s;
    entry_t           new_entry_s;
    entry_t           head_s;

    // Handshake decode: a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        event_s     = bus.ret_valid && trace_en;
        not_empty_s = (count_r != {CW{1'b0}});
        full_s      = (count_r == CW'(DEPTH));
        pop_s       = not_empty_s && bus.out_ready;
        push_s      = event_s && (!full_s || pop_s);
        drop_s      = event_s && !push_s;
        head_s      = mem_r[rd_ptr_r];
    end

    // Build the entry to store; writes to x0 are architecturally invisible.
    always_comb begin
        new_entry_s.pc    = bus.ret_pc;
        new_entry_s.inst  = bus.ret_inst;
        new_entry_s.rd_we = bus.ret_rd_we && (bus.ret_rd != 5'd0);
        new_entry_s.rd    = bus.ret_rd;
        new_entry_s.wdata = bus.ret_rd_wdata;
        new_entry_s.cycle = cycle_r;
        new_entry_s.seq   = seq_r;
        new_entry_s.gap   = gap_pending_r;
    end

    // Occupancy update from push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Pointers, occupancy, cycle and sequence counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_r  <= {CYC_W{1'b0}};
            seq_r    <= 32'd0;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            cycle_r <= cycle_r + CYC_W'(1);
            count_r <= count_next_s;
            if (event_s) begin
                seq_r <= seq_r + 32'd1;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Drop accounting; the gap marker is consumed by the next accepted entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r    <= 16'd0;
            gap_pending_r <= 1'b0;
        end else begin
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            if (push_s) begin
                gap_pending_r <= 1'b0;
            end else if (drop_s) begin
                gap_pending_r <= 1'b1;
            end else begin
                gap_pending_r <= gap_pending_r;
            end
        end
    end

    // Head slot drives the outputs; forced to zero when empty so reset shows all zeros.
    always_comb begin
        bus.out_valid = not_empty_s;
        bus.out_pc    = not_empty_s ? head_s.pc    : 32'h0;
        bus.out_inst  = not_empty_s ? head_s.inst  : 32'h0;
        bus.out_rd_we = not_empty_s ? head_s.rd_we : 1'b0;
        bus.out_rd    = not_empty_s ? head_s.rd    : 5'd0;
        bus.out_wdata = not_empty_s ? head_s.wdata : 32'h0;
        bus.out_cycle = not_empty_s ? head_s.cycle : {CYC_W{1'b0}};
        bus.out_seq   = not_empty_s ? head_s.seq   : 32'h0;
        bus.out_gap   = not_empty_s ? head_s.gap   : 1'b0;
        drop_cnt      = drop_cnt_r;
        level         = count_r;
    end
endmodule

// File: tb/tb_retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_fifo
// Scoreboard bench for retire_trace_fifo: the driver keeps a queue-level
// reference model and pushes expected entries; an independent monitor pops and
// compares whenever the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_retire_trace_fifo;
    localparam int DEPTH = 16;
    localparam int CYC_W = 64;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [63:0] cyc;
        logic [31:0] seq;
        logic        gap;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_en;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    retire_trace_fifo_if #(.CYC_W(CYC_W)) bus ();

    retire_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .trace_en (trace_en),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    ent_t        exp_q[$];
    int          m_count;
    logic [31:0] m_seq;
    logic [63:0] m_cycle;
    logic        m_gap;
    logic [15:0] m_drop;
    int          exp_level = 0;
    logic [15:0] exp_drop  = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.ret_valid    = 1'b0;
        bus.ret_pc       = 32'h0;
        bus.ret_inst     = 32'h0;
        bus.ret_rd_we    = 1'b0;
        bus.ret_rd       = 5'd0;
        bus.ret_rd_wdata = 32'h0;
        bus.out_ready    = 1'b0;
        trace_en         = 1'b1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count   = 0;
        m_seq     = 32'd0;
        m_cycle   = 64'd0;
        m_gap     = 1'b0;
        m_drop    = 16'd0;
        exp_level = 0;
        exp_drop  = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus at a negedge, advance the model, wait next negedge.
    task automatic step(input bit rv, input bit en, input bit rdy,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input bit we, input logic [4:0] rd, input logic [31:0] wd);
        bit   ev, pop, acc;
        ent_t e;
        bus.ret_valid    = rv;
        bus.ret_pc       = pc;
        bus.ret_inst     = inst;
        bus.ret_rd_we    = we;
        bus.ret_rd       = rd;
        bus.ret_rd_wdata = wd;
        bus.out_ready    = rdy;
        trace_en         = en;
        exp_level = m_count;
        exp_drop  = m_drop;
        ev  = rv && en;
        pop = (m_count != 0) && rdy;
        acc = ev && ((m_count < DEPTH) || pop);
        if (acc) begin
            e.pc  = pc;
            e.inst = inst;
            e.we  = we && (rd != 5'd0);
            e.rd  = rd;
            e.wd  = wd;
            e.cyc = m_cycle;
            e.seq = m_seq;
            e.gap = m_gap;
            exp_q.push_back(e);
            m_gap = 1'b0;
        end else if (ev) begin
            m_gap = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (ev) m_seq = m_seq + 32'd1;
        m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
        m_cycle = m_cycle + 64'd1;
        @(negedge clk);
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, 1'b1, rdy, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic rand_ret(input bit en, input bit rdy);
        step(1'b1, en, rdy, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
    endtask

    // Monitor: status every cycle, entry compare on each completed handshake.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("out_valid", 64'(bus.out_valid), 64'(exp_level != 0));
            chk("level", 64'(level), 64'(exp_level));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual=valid expected=empty t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
                    chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
                    chk("out_rd_we", 64'(bus.out_rd_we), 64'(e.we));
                    chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                    chk("out_wdata", 64'(bus.out_wdata), 64'(e.wd));
                    chk("out_cycle", bus.out_cycle, e.cyc);
                    chk("out_seq", 64'(bus.out_seq), 64'(e.seq));
                    chk("out_gap", 64'(bus.out_gap), 64'(e.gap));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pct;
        int guard;
        idle_inputs();
        model_clear();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_seq", 64'(bus.out_seq), 64'd0);
        chk("rst_out_cycle", bus.out_cycle, 64'd0);
        @(negedge clk);
        do_reset();

        // Three back-to-back retires, logger always ready.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'h00000013, 1'b1, 5'd1, 32'(i));
        repeat (3) idle_step(1'b1);

        // Fill with no drain: 16 stored, 4 dropped; then one retire with ready.
        for (int i = 0; i < 20; i++) rand_ret(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h1000, 32'h1, 1'b1, 5'd2, 32'h2);
        repeat (20) idle_step(1'b1);

        // Full FIFO with push and pop together: no drop, level stays full.
        for (int i = 0; i < 16; i++) rand_ret(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h2000, 32'h2, 1'b0, 5'd3, 32'h3);
        idle_step(1'b0);
        repeat (20) idle_step(1'b1);

        // Write to x0 is masked but rd/wdata pass through.
        step(1'b1, 1'b1, 1'b1, 32'h3000, 32'h00000033, 1'b1, 5'd0, 32'hDEADBEEF);
        repeat (2) idle_step(1'b1);

        // Disabled capture: retires ignored, seq and drops unchanged.
        for (int i = 0; i < 5; i++) rand_ret(1'b0, 1'b1);
        rand_ret(1'b1, 1'b1);
        repeat (2) idle_step(1'b1);

        // Async reset mid-stream with seven entries queued.
        for (int i = 0; i < 7; i++) rand_ret(1'b1, 1'b0);
        idle_inputs();
        exp_level = m_count;
        exp_drop  = m_drop;
        #3 rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_level", 64'(level), 64'd0);
        chk("async_drop", 64'(drop_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rand_ret(1'b1, 1'b1);
        repeat (2) rand_ret(1'b1, 1'b1);
        repeat (2) idle_step(1'b1);

        // Randomized traffic: a congested phase then a mostly-ready phase.
        for (int ph = 0; ph < 2; ph++) begin
            pct = (ph == 0) ? 25 : 80;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 99) < 75)
                    rand_ret(($urandom_range(0, 7) != 0), ($urandom_range(0, 99) < pct));
                else
                    idle_step(($urandom_range(0, 99) < pct));
            end
        end

        guard = 0;
        while (m_count != 0 && guard < 100) begin
            idle_step(1'b1);
            guard++;
        end
        idle_step(1'b0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Capture stage directly upstream of the instruction-trace logger/disassembler.
- Samples every retired instruction from the writeback stage: PC, instruction word, register writeback.
- Tags each entry with a cycle stamp and a retire sequence number, and buffers entries in a FIFO.
- Presents entries to the logger over a valid/ready handshake, so logging back-pressure never stalls the core. Entries are dropped, with accounting, when the FIFO is full.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, ≥2.
- CYC_W, 64, width of the free-running cycle counter and the out_cycle stamp.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- trace_en  in  1  capture enable; when 0, retires are ignored (not counted, not dropped).
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  32  PC of the retiring instruction.
- ret_inst  in  32  raw instruction word.
- ret_rd_we  in  1  retiring instruction writes rd.
- ret_rd  in  5  destination register index.
- ret_rd_wdata  in  32  writeback value.
- out_valid  out  1  head entry available.
- out_ready  in  1  logger accepts the head entry.
- out_pc  out  32  head entry PC.
- out_inst  out  32  head entry instruction word.
- out_rd_we  out  1  head entry writeback flag (already masked for x0).
- out_rd  out  5  head entry rd.
- out_wdata  out  32  head entry writeback data.
- out_cycle  out  CYC_W  cycle stamp of head entry.
- out_seq  out  32  retire sequence number of head entry.
- out_gap  out  1  one or more retires were dropped immediately before this entry.
- drop_cnt  out  16  total dropped retires, saturating.
- level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): all outputs 0; cycle counter, seq counter, rd/wr pointers, count, drop_cnt and gap_pending all 0. Storage contents don't care. Takes effect immediately, including mid-transfer; the head entry is lost.
- Cycle counter:
  - Increments by 1 every clk edge after reset; wraps modulo 2^CYC_W.
  - An entry captured on edge N carries the counter value present before that edge.
- Capture: a "retire event" is ret_valid && trace_en. Each retire event is either accepted or dropped.
- Sequence counter:
  - Increments by 1 on every retire event, whether accepted or dropped.
  - The stored seq is the value before the increment: the first retire after reset is seq 0.
  - Wraps at 2^32.
- Accept condition: count < DEPTH, or (count == DEPTH and out_valid && out_ready in the same cycle). Simultaneous push and pop on a full FIFO succeeds and count stays DEPTH.
- Drop:
  - A retire event that is not accepted increments drop_cnt, saturating at 16'hFFFF.
  - It sets gap_pending.
  - seq still advances, so the seq gap is visible downstream.
- Gap flag:
  - An accepted entry stores gap = gap_pending.
  - gap_pending clears on that same edge.
  - A drop and an accept cannot coincide, since there is at most one retire per cycle.
- x0 masking: stored rd_we = ret_rd_we && (ret_rd != 0). rd and wdata are stored unmodified.
- Output:
  - First-word-fall-through; out_* are driven from the head slot.
  - out_valid = (count != 0).
  - An entry captured on edge N is visible at out_valid after edge N; latency 1 cycle from ret_valid.
  - Pop on out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
  - out_ready while empty has no effect.
- Pointers: wrap modulo DEPTH.
- Count/level:
  - count += push − pop.
  - level = count.
  - Simultaneous push and pop on an empty FIFO is impossible, because pop requires out_valid.
- trace_en deasserted: FIFO continues draining; no counters advance except the cycle counter.

Test Plan:
- Reset then 3 retires: PC 0x0, 0x4, 0x8 on consecutive cycles, out_ready=1 → out_seq 0,1,2; out_cycle strictly increasing by 1; out_gap=0; out_valid first high 1 cycle after the first ret_valid.
- DEPTH=16, out_ready=0, 20 back-to-back retires → level=16; drop_cnt=4. Then release out_ready and issue one more retire → 17th entry popped has out_seq=20, out_gap=1; first 16 entries have seq 0..15, gap=0.
- FIFO full, out_ready=1 and ret_valid=1 in the same cycle → no drop; level stays 16; new entry appended after the drained ones.
- Retire with ret_rd=0, ret_rd_we=1, wdata=0xDEADBEEF → out_rd_we=0, out_rd=0, out_wdata=0xDEADBEEF.
- trace_en=0 with 5 retires, then trace_en=1 and 1 retire → single entry with seq equal to the pre-disable value; drop_cnt unchanged.
- rst asserted asynchronously mid-stream with level=7 → out_valid, level, drop_cnt = 0 immediately. After release, the next retire gets seq 0 and out_cycle counts from 0.
